// File: rtl/uart_rx_fmt.sv
// Parametrised oversampling UART receiver: 2-flop synchroniser, 3-sample majority
// voting, optional parity, 1/2 stop bits, one-entry valid/ready holding register.
module uart_rx_fmt #(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned S         = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] d_out,
  output logic            valid,
  input  logic            ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            break_det,
  output logic            busy
);

  localparam int unsigned SW = $clog2(S);
  localparam int unsigned NW = $clog2(DBIT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(S - 1);
  localparam logic [SW-1:0] S_V0   = SW'(S / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(S / 2);
  localparam logic [SW-1:0] S_V2   = SW'(S / 2 + 1);
  localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [1:0]      samp_q, samp_d;
  logic            bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            facc_q, facc_d;
  logic            sone_q, sone_d;
  logic [DBIT-1:0] d_out_q, d_out_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            overrun_q, overrun_d;
  logic            brk_q, brk_d;
  logic            busy_q, busy_d;

  logic rxs;
  logic maj_c, tick_last_c, tick_vote_c, par_exp_c, perr_c, brk_c;

  assign rxs         = sync_q[1];
  assign maj_c       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign tick_last_c = s_tick && (s_q == S_LAST);
  assign tick_vote_c = s_tick && (s_q == S_V2);
  assign par_exp_c   = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);
  assign perr_c      = (PARITY != 0) && (par_q != par_exp_c);
  // Break: all-zero data, zero parity bit and every stop bit (including this one) low
  assign brk_c       = (shreg_q == '0) && ((PARITY == 0) || !par_q) && !(sone_q | maj_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b11;
      s_q       <= '0;
      n_q       <= '0;
      samp_q    <= 2'b11;
      bit_q     <= 1'b1;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      facc_q    <= 1'b0;
      sone_q    <= 1'b0;
      d_out_q   <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      brk_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      s_q       <= s_d;
      n_q       <= n_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      facc_q    <= facc_d;
      sone_q    <= sone_d;
      d_out_q   <= d_out_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      brk_q     <= brk_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], rx};
    s_d       = s_q;
    n_d       = n_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    facc_d    = facc_q;
    sone_d    = sone_q;
    d_out_d   = d_out_q;
    valid_d   = valid_q & ~ready;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    brk_d     = 1'b0;

    if (s_tick) begin
      if (s_q == S_V0) samp_d[0] = rxs;
      if (s_q == S_V1) samp_d[1] = rxs;
      if (s_q == S_V2) bit_d = maj_c;
    end
    if (s_tick && (state_q != ST_IDLE) && (state_q != ST_BRK)) begin
      s_d = tick_last_c ? '0 : s_q + SW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        s_d = '0;
        n_d = '0;
        if (!rxs) begin
          state_d = ST_START;
          facc_d  = 1'b0;
          sone_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tick_vote_c && maj_c) begin
          state_d = ST_IDLE;
          s_d     = '0;
        end else if (tick_last_c) begin
          state_d = ST_DATA;
          n_d     = '0;
        end
      end
      ST_DATA: begin
        if (tick_last_c) begin
          shreg_d = {bit_q, shreg_q[DBIT-1:1]};
          if (n_q == N_DLAST) begin
            n_d     = '0;
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
      ST_PAR: begin
        if (tick_last_c) begin
          par_d   = bit_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Last stop bit finishes at mid-bit so the next start edge is not missed
        if (tick_vote_c && (n_q == N_SLAST)) begin
          s_d = '0;
          if (brk_c) begin
            brk_d   = 1'b1;
            state_d = ST_BRK;
          end else begin
            state_d = ST_IDLE;
            if (valid_q && !ready) begin
              overrun_d = 1'b1;
            end else begin
              d_out_d = shreg_q;
              perr_d  = perr_c;
              ferr_d  = facc_q | ~maj_c;
              valid_d = 1'b1;
            end
          end
        end else if (tick_vote_c) begin
          facc_d = facc_q | ~maj_c;
          sone_d = sone_q | maj_c;
        end else if (tick_last_c) begin
          n_d = n_q + NW'(1);
        end
      end
      ST_BRK: begin
        s_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign d_out      = d_out_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign break_det  = brk_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fmt.sv
// Randomised frame-level bench for uart_rx_fmt: an 8N1 and an 8E2 instance checked
// against an expected-event model derived from the frame contents.
module tb_uart_rx_fmt;
  localparam int unsigned S = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_fmt #(.DBIT(8), .S(S), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick), .d_out(dout_a),
    .valid(valid_a), .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .break_det(brk_a), .busy(busy_a));

  uart_rx_fmt #(.DBIT(8), .S(S), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick), .d_out(dout_b),
    .valid(valid_b), .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .break_det(brk_b), .busy(busy_b));

  // kind: 0 = frame loaded, 1 = overrun, 2 = break
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  bit exp_full_a = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected frame outcome from its line contents (idx 1 = even parity, two stop bits)
  function automatic exp_t model(input int idx, input logic [7:0] d, input logic pb,
                                 input logic st0, input logic st1);
    exp_t e;
    bit has_par  = (idx == 1);
    bit stops_lo = (idx == 1) ? (!st0 && !st1) : !st0;
    bit any_lo   = (idx == 1) ? (!st0 || !st1) : !st0;
    bit odd_ones = ($countones(d) % 2) == 1;
    e.data = d;
    e.ferr = any_lo;
    e.perr = has_par && (pb != odd_ones);
    e.kind = (d == 8'h00 && (!has_par || !pb) && stops_lo) ? 2'd2 : 2'd0;
    return e;
  endfunction

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int idx, input logic v);
    if (idx == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic drive_bit(input int idx, input logic b, input bit glitch);
    set_rx(idx, b);
    if (glitch) begin
      hold(S / 2);
      set_rx(idx, 1'b0);
      hold(1);
      set_rx(idx, b);
      hold(S / 2 - 1);
    end else begin
      hold(S);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic pb,
                      input logic st0, input logic st1, input int glitch);
    logic [11:0] bits;
    int nb;
    exp_t e;
    bits = '0;
    nb = 1;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = d[i];
      nb++;
    end
    if (idx == 1) begin
      bits[nb] = pb;
      nb++;
    end
    bits[nb] = st0;
    nb++;
    if (idx == 1) begin
      bits[nb] = st1;
      nb++;
    end
    e = model(idx, d, pb, st0, st1);
    if (idx == 0 && e.kind == 2'd0) begin
      if (exp_full_a && !ready_a) e.kind = 2'd1;
      else if (!ready_a) exp_full_a = 1'b1;
    end
    if (idx == 0) q_a.push_back(e);
    else q_b.push_back(e);
    for (int i = 0; i < nb; i++) drive_bit(idx, bits[i], (i == glitch));
  endtask

  // Idle gap; every expected event must have been seen by its end
  task automatic gap_check(input int idx, input int n);
    int sz;
    set_rx(idx, 1'b1);
    hold(n);
    sz = (idx == 0) ? q_a.size() : q_b.size();
    chk((idx == 0) ? "a_event_timeout" : "b_event_timeout", sz, 0);
    if (idx == 0) q_a.delete();
    else q_b.delete();
  endtask

  task automatic observe(input int idx, input logic v, input logic pv, input logic pr,
                         input logic ov, input logic bk, input logic [7:0] d,
                         input logic pe, input logic fe);
    exp_t e;
    int kind;
    int sz;
    kind = bk ? 2 : (ov ? 1 : ((v && (!pv || pr)) ? 0 : -1));
    if (kind >= 0) begin
      sz = (idx == 0) ? q_a.size() : q_b.size();
      if (sz == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_event actual=%0d required=none", (idx == 0) ? "a" : "b", kind);
      end else begin
        if (idx == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        chk((idx == 0) ? "a_event_kind" : "b_event_kind", kind, e.kind);
        if (kind == 0) begin
          chk((idx == 0) ? "a_d_out" : "b_d_out", d, e.data);
          chk((idx == 0) ? "a_parity_err" : "b_parity_err", pe, e.perr);
          chk((idx == 0) ? "a_frame_err" : "b_frame_err", fe, e.ferr);
        end
      end
    end
  endtask

  logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      pv_a <= 1'b0;
      pv_b <= 1'b0;
    end else begin
      observe(0, valid_a, pv_a, pr_a, ovr_a, brk_a, dout_a, perr_a, ferr_a);
      observe(1, valid_b, pv_b, pr_b, ovr_b, brk_b, dout_b, perr_b, ferr_b);
      pv_a <= valid_a;
      pr_a <= ready_a;
      pv_b <= valid_b;
      pr_b <= ready_b;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_d_out", dout_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_parity_err", perr_a, 0);
    chk("rst_frame_err", ferr_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_break_det", brk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_b_busy", busy_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int idx;
    hold(3);
    chk_reset_vals();
    reset = 1'b0;
    hold(4);

    // 8N1 frame with consumer ready
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1);
    gap_check(0, 2 * S);
    chk("a5_d_out", dout_a, 8'hA5);
    chk("a5_valid_one_cycle", valid_a, 0);
    chk("a5_frame_err", ferr_a, 0);

    // Even parity: 0x07 has odd ones, so the correct parity bit is 1
    send(1, 8'h07, 1'b0, 1'b1, 1'b1, -1);
    gap_check(1, 2 * S);
    chk("par_bad_flag", perr_b, 1);
    chk("par_bad_data", dout_b, 8'h07);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    gap_check(1, 2 * S);
    chk("par_good_flag", perr_b, 0);

    // False start: 4 ticks low
    set_rx(0, 1'b0);
    hold(4);
    set_rx(0, 1'b1);
    hold(2);
    chk("false_start_busy_hi", busy_a, 1);
    hold(10);
    chk("false_start_busy_lo", busy_a, 0);
    gap_check(0, 2 * S);

    // Single-cycle low glitch mid data bit 3 of 0xFF
    send(0, 8'hFF, 1'b0, 1'b1, 1'b1, 4);
    gap_check(0, 2 * S);
    chk("glitch_d_out", dout_a, 8'hFF);

    // Overrun with consumer stalled
    ready_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, 1'b1, -1);
    gap_check(0, 2 * S);
    send(0, 8'h22, 1'b0, 1'b1, 1'b1, -1);
    gap_check(0, 2 * S);
    chk("ovr_hold_data", dout_a, 8'h11);
    chk("ovr_hold_valid", valid_a, 1);
    ready_a = 1'b1;
    exp_full_a = 1'b0;
    hold(2);
    chk("ovr_valid_drop", valid_a, 0);

    // Break: line low for 12 bit periods on both instances
    send(0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    hold(2 * S);
    gap_check(0, 2 * S);
    chk("brk_no_valid", valid_a, 0);
    send(0, 8'h3C, 1'b0, 1'b1, 1'b1, -1);
    gap_check(0, 2 * S);
    chk("after_brk_d_out", dout_a, 8'h3C);
    send(1, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    gap_check(1, 2 * S);

    // Reset during DATA of 0x5A, then a clean 0x5A
    v = 8'h5A;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, v[i], 1'b0);
    reset = 1'b1;
    hold(1);
    chk_reset_vals();
    rx_a = 1'b1;
    hold(2);
    reset = 1'b0;
    gap_check(0, 2 * S);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1);
    gap_check(0, 2 * S);
    chk("post_rst_d_out", dout_a, 8'h5A);

    // Randomised frames
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic pb, s0, s1;
      int g;
      idx = $urandom_range(0, 1);
      d = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      if (idx == 0) pb = 1'b0;
      send(idx, d, pb, s0, s1, g);
      gap_check(idx, 2 * S + int'($urandom_range(0, 16)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fmt.md
# uart_rx_fmt

Parametrised UART receiver: the next-generation receive front end of the UART banner datapath, replacing the fixed 8N1 receiver. Runs from an external oversampling tick (`s_tick`) supplied by the shared baud generator. Adds configurable data width, parity, stop-bit count, an input synchroniser, and 3-sample majority voting. Delivers each frame through a one-entry valid/ready holding register with per-frame error flags, plus overrun and break indication.

## Interface
- `DBIT`, 8: data bits per frame, 5..9, LSB first.
- `S`, 16: `s_tick`s per bit period, even, ≥ 8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous, idle high.
- `s_tick`  in  1  one-`clk`-wide oversampling strobe, S per bit.
- `d_out`  out  DBIT  received data word (holding register).
- `valid`  out  1  holding register occupied.
- `ready`  in  1  consumer accepts `d_out` when `valid && ready`.
- `parity_err`  out  1  parity mismatch for the frame in `d_out`.
- `frame_err`  out  1  a stop bit sampled low for the frame in `d_out`.
- `overrun`  out  1  one-cycle pulse: frame completed while `valid && !ready`; that frame is dropped.
- `break_det`  out  1  one-cycle pulse: break condition detected.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (flops reset to 1); all logic below uses the synchronised `rxs`.
- The bit-tick counter `s` runs 0..S-1 and advances only on `s_tick`. Majority samples are taken at `s` = S/2-1, S/2, S/2+1. The bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- IDLE: `s`=0, bit index n=0. When `rxs`==0, go to START.
- START: at `s`=S/2+1, a majority of 1 is a false start: return to IDLE, no outputs. Otherwise, at `s`=S-1, go to DATA.
- DATA: at `s`=S-1, shift the voted bit into the MSB of the shift register (LSB-first assembly). After DBIT bits, go to PAR if PARITY≠0, else STOP.
- PAR: the voted bit is checked against XOR(data) (even) or ~XOR(data) (odd). At `s`=S-1, go to STOP.
- STOP: each stop bit is voted; a 0 sets the frame's framing flag. The first stop bit (when STOP_BITS=2) is held to `s`=S-1. The last stop bit completes at `s`=S/2+1 for early resynchronisation.
- On completion, break check: if data==0, parity bit (if any)==0, and every stop bit==0, pulse `break_det` and go to BRK. No `valid`, no overrun check.
- Otherwise, if `valid && !ready`, pulse `overrun`, drop the frame, and leave the holding register unchanged. If not, load `d_out`, `parity_err`, `frame_err` and set `valid`. Then return to IDLE.
- BRK: wait for `rxs`==1, then go to IDLE.
- Handshake: `valid` clears on the cycle after `valid && ready`. A completion in the same cycle as an accept is not an overrun: the new frame loads and `valid` stays 1.

## Timing
- Reset values: `d_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `break_det`=0, `busy`=0; FSM in IDLE; synchroniser flops 1.
- The falling edge of `rx` reaches the FSM 2 `clk` later. `busy` rises the cycle after the FSM sees `rxs`==0.
- Frame latency from the start edge to `valid` is (1 + DBIT + P + STOP_BITS - 1)·S + S/2 + 2 ticks, plus ≤3 `clk` (P = 1 if PARITY≠0, else 0).
- `valid`, `overrun`, `break_det` and the error flags are registered outputs, asserted together in one cycle.
- Reset mid-frame aborts immediately to the reset state. A partially received frame never produces `valid`.

## Test plan
- 8N1, S=16, `s_tick` every cycle, send 0xA5 with `ready`=1 -> `d_out`=0xA5, `valid` for 1 cycle, `parity_err`=`frame_err`=0.
- PARITY=2, send 0x07 with parity bit 0 (wrong) -> `d_out`=0x07, `parity_err`=1. Resend with correct parity bit 1 -> `parity_err`=0.
- `rx` low for 4 ticks, then high -> no `valid`, `busy` returns to 0 by tick 9.
- Single-tick low glitch at `s`=S/2 of data bit 3 while sending 0xFF -> `d_out`=0xFF (majority vote).
- Send 0x11, then 0x22, with `ready`=0 -> `d_out`=0x11, one `overrun` pulse. Raise `ready` -> `valid` drops.
- Hold `rx` low for 12 bit periods -> one `break_det`, no `valid`. Release, then send 0x3C -> `d_out`=0x3C.
- Assert `reset` during DATA of 0x5A -> all outputs at reset values. A subsequent 0x5A is received correctly.
